// File: rtl/fb_port_arbiter_if.sv
// Frame-buffer arbiter bus: capture write port, display read port, RAM port and status flags.
// slave = arbiter side, master = client/RAM side.
interface fb_port_arbiter_if #(
  parameter int unsigned ADDR_W = 17,
  parameter int unsigned DATA_W = 8
);
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_busy;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;
  logic              clr_err;
  logic              overrun;
  logic              oob_err;

  modport slave (
    input  wr_req, wr_addr, wr_data, rd_req, rd_addr, mem_rdata, clr_err,
    output rd_busy, rd_data, rd_valid, mem_addr, mem_wdata, mem_we, overrun, oob_err
  );

  modport master (
    output wr_req, wr_addr, wr_data, rd_req, rd_addr, mem_rdata, clr_err,
    input  rd_busy, rd_data, rd_valid, mem_addr, mem_wdata, mem_we, overrun, oob_err
  );
endinterface

// File: rtl/fb_port_arbiter.sv
// Single-port frame-buffer arbiter: edge-detected capture writes vs. pulsed display reads.
// Optional write bounds check enabled by defining FB_ARB_BOUNDS_CHECK_EN.
module fb_port_arbiter #(
  parameter int unsigned ADDR_W       = 17,
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned FRAME_PIXELS = 76800
) (
  input logic               clk,
  input logic               reset,
  fb_port_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StWrite, StRead, StRdWait} state_e;

  localparam logic [ADDR_W:0] FrameLimit = (ADDR_W+1)'(FRAME_PIXELS);

  state_e            state_q;
  logic              wr_req_q;
  logic              wr_armed_q;
  logic              wr_pend_q;
  logic              rd_pend_q;
  logic              last_read_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;
  logic [ADDR_W-1:0] rd_addr_q;

  logic wr_event;
  logic wr_oob;
  logic wr_clearing;

  // wr_armed_q keeps a level already high at reset release from counting as a new write.
  assign wr_event    = bus.wr_req & ~wr_req_q & wr_armed_q;
  assign wr_clearing = (state_q == StWrite);

`ifdef FB_ARB_BOUNDS_CHECK_EN
  assign wr_oob = wr_event & ({1'b0, bus.wr_addr} >= FrameLimit);
`else
  logic unused_frame_limit;
  assign unused_frame_limit = ^FrameLimit;
  assign wr_oob = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      wr_req_q      <= 1'b0;
      wr_armed_q    <= 1'b0;
      wr_pend_q     <= 1'b0;
      rd_pend_q     <= 1'b0;
      last_read_q   <= 1'b1;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      rd_addr_q     <= '0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.rd_data   <= '0;
      bus.rd_valid  <= 1'b0;
      bus.rd_busy   <= 1'b0;
      bus.overrun   <= 1'b0;
      bus.oob_err   <= 1'b0;
    end else begin
      wr_req_q     <= bus.wr_req;
      bus.rd_valid <= 1'b0;
      if (!bus.wr_req) wr_armed_q <= 1'b1;

      if (bus.clr_err) begin
        bus.overrun <= 1'b0;
        bus.oob_err <= 1'b0;
      end

      // Later assignments win, so an error event beats a same-edge clear.
      if (wr_clearing) wr_pend_q <= 1'b0;
      if (wr_oob) begin
        bus.oob_err <= 1'b1;
      end else if (wr_event) begin
        if (wr_pend_q && !wr_clearing) begin
          bus.overrun <= 1'b1;
        end else begin
          wr_pend_q <= 1'b1;
          wr_addr_q <= bus.wr_addr;
          wr_data_q <= bus.wr_data;
        end
      end

      if (bus.rd_req && !bus.rd_busy) begin
        rd_addr_q   <= bus.rd_addr;
        rd_pend_q   <= 1'b1;
        bus.rd_busy <= 1'b1;
      end

      case (state_q)
        StIdle: begin
          if (wr_pend_q && (!rd_pend_q || last_read_q)) begin
            state_q       <= StWrite;
            bus.mem_we    <= 1'b1;
            bus.mem_addr  <= wr_addr_q;
            bus.mem_wdata <= wr_data_q;
            last_read_q   <= 1'b0;
          end else if (rd_pend_q) begin
            state_q      <= StRead;
            bus.mem_we   <= 1'b0;
            bus.mem_addr <= rd_addr_q;
            last_read_q  <= 1'b1;
          end
        end
        StWrite: begin
          bus.mem_we <= 1'b0;
          state_q    <= StIdle;
        end
        StRead: begin
          state_q <= StRdWait;
        end
        StRdWait: begin
          bus.rd_data  <= bus.mem_rdata;
          bus.rd_valid <= 1'b1;
          rd_pend_q    <= 1'b0;
          bus.rd_busy  <= 1'b0;
          state_q      <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Bench for fb_port_arbiter: directed timing cases, then random traffic against a
// transaction-level model (write order, read data, latency bounds).
module tb_fb_port_arbiter;
  localparam int unsigned AW = 17;
  localparam int unsigned DW = 8;
  localparam int unsigned FP = 76800;
`ifdef FB_ARB_BOUNDS_CHECK_EN
  localparam bit BoundsEn = 1'b1;
`else
  localparam bit BoundsEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;

  fb_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  fb_port_arbiter #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .FRAME_PIXELS(FP)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Unwritten locations read back a fixed address pattern.
  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    return a[7:0] ^ a[15:8] ^ {7'b0, a[16]} ^ 8'h2C;
  endfunction

  logic [DW-1:0] ram     [0:(1<<AW)-1];
  bit            written [0:(1<<AW)-1];

  always @(posedge clk) begin
    if (bus.mem_we) begin
      ram[bus.mem_addr]     <= bus.mem_wdata;
      written[bus.mem_addr] <= 1'b1;
    end
    bus.mem_rdata <= written[bus.mem_addr] ? ram[bus.mem_addr] : pat(bus.mem_addr);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [AW-1:0] qa [$];
  logic [DW-1:0] qd [$];
  logic [AW-1:0] ea;
  logic [DW-1:0] ed;
  logic [DW-1:0] rd_exp;
  bit wr_out;
  bit rd_out;
  bit stim;
  int wr_age;
  int rd_age;
  int cnt;

  initial begin
    bus.wr_req  = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.rd_req  = 1'b0;
    bus.rd_addr = '0;
    bus.clr_err = 1'b0;
    wr_out = 1'b0;
    rd_out = 1'b0;
    wr_age = 0;
    rd_age = 0;

    // Reset state
    #2 reset = 1'b0;
    #1;
    chk("rst_mem_we",    32'(bus.mem_we),    32'd0);
    chk("rst_mem_addr",  32'(bus.mem_addr),  32'd0);
    chk("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
    chk("rst_rd_data",   32'(bus.rd_data),   32'd0);
    chk("rst_rd_valid",  32'(bus.rd_valid),  32'd0);
    chk("rst_rd_busy",   32'(bus.rd_busy),   32'd0);
    chk("rst_overrun",   32'(bus.overrun),   32'd0);
    chk("rst_oob_err",   32'(bus.oob_err),   32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    tick();
    tick();

    // Level held 10 cycles -> one write, issued one edge after the event
    bus.wr_addr = 17'h5;
    bus.wr_data = 8'hA5;
    bus.wr_req  = 1'b1;
    tick();
    chk("wr_we_at_k", 32'(bus.mem_we), 32'd0);
    tick();
    chk("wr_we",    32'(bus.mem_we),    32'd1);
    chk("wr_addr",  32'(bus.mem_addr),  32'h5);
    chk("wr_wdata", 32'(bus.mem_wdata), 32'hA5);
    cnt = 0;
    repeat (8) begin
      tick();
      cnt += int'(bus.mem_we);
    end
    chk("wr_single", 32'(cnt), 32'd0);
    bus.wr_req = 1'b0;
    tick();

    // Read: valid three edges after request; second request while busy ignored
    bus.rd_addr = 17'h10;
    bus.rd_req  = 1'b1;
    tick();
    chk("rd_busy_k", 32'(bus.rd_busy), 32'd1);
    bus.rd_addr = 17'h20;
    tick();
    bus.rd_req = 1'b0;
    chk("rd_mem_addr", 32'(bus.mem_addr), 32'h10);
    chk("rd_no_we",    32'(bus.mem_we),   32'd0);
    chk("rd_valid_k1", 32'(bus.rd_valid), 32'd0);
    tick();
    chk("rd_valid_k2", 32'(bus.rd_valid), 32'd0);
    tick();
    chk("rd_valid_k3", 32'(bus.rd_valid), 32'd1);
    chk("rd_data_k3",  32'(bus.rd_data),  32'h3C);
    chk("rd_busy_k3",  32'(bus.rd_busy),  32'd0);
    tick();
    chk("rd_valid_k4", 32'(bus.rd_valid), 32'd0);
    chk("rd_data_hold", 32'(bus.rd_data), 32'h3C);
    cnt = 0;
    repeat (6) begin
      tick();
      cnt += int'(bus.rd_valid);
    end
    chk("rd_busy_ignored", 32'(cnt), 32'd0);

    // Contention: grants W, R, W with a write landing on the clearing edge
    bus.wr_addr = 17'h40;
    bus.wr_data = 8'h11;
    bus.wr_req  = 1'b1;
    bus.rd_addr = 17'h10;
    bus.rd_req  = 1'b1;
    tick();
    bus.rd_req = 1'b0;
    bus.wr_req = 1'b0;
    tick();
    chk("arb_w1_we",   32'(bus.mem_we),   32'd1);
    chk("arb_w1_addr", 32'(bus.mem_addr), 32'h40);
    bus.wr_addr = 17'h41;
    bus.wr_data = 8'h22;
    bus.wr_req  = 1'b1;
    tick();
    chk("arb_gap_we", 32'(bus.mem_we), 32'd0);
    bus.wr_req = 1'b0;
    tick();
    chk("arb_r_addr", 32'(bus.mem_addr), 32'h10);
    chk("arb_r_we",   32'(bus.mem_we),   32'd0);
    tick();
    tick();
    chk("arb_r_valid", 32'(bus.rd_valid), 32'd1);
    chk("arb_r_data",  32'(bus.rd_data),  32'h3C);
    tick();
    chk("arb_w2_we",    32'(bus.mem_we),    32'd1);
    chk("arb_w2_addr",  32'(bus.mem_addr),  32'h41);
    chk("arb_w2_wdata", 32'(bus.mem_wdata), 32'h22);
    chk("arb_no_ovr",   32'(bus.overrun),   32'd0);
    tick();
    tick();

    // Overrun: second write while first waits behind a read
    bus.rd_addr = 17'h20;
    bus.rd_req  = 1'b1;
    tick();
    bus.rd_req  = 1'b0;
    bus.wr_addr = 17'h50;
    bus.wr_data = 8'h33;
    bus.wr_req  = 1'b1;
    tick();
    bus.wr_req = 1'b0;
    tick();
    bus.wr_addr = 17'h51;
    bus.wr_data = 8'h44;
    bus.wr_req  = 1'b1;
    tick();
    chk("ovr_set",      32'(bus.overrun),  32'd1);
    chk("ovr_rd_valid", 32'(bus.rd_valid), 32'd1);
    chk("ovr_rd_data",  32'(bus.rd_data),  32'(pat(17'h20)));
    bus.wr_req = 1'b0;
    tick();
    chk("ovr_we",    32'(bus.mem_we),    32'd1);
    chk("ovr_addr",  32'(bus.mem_addr),  32'h50);
    chk("ovr_wdata", 32'(bus.mem_wdata), 32'h33);
    cnt = 0;
    repeat (6) begin
      tick();
      cnt += int'(bus.mem_we);
    end
    chk("ovr_dropped_we",  32'(cnt), 32'd0);
    chk("ovr_dropped_mem", 32'(written[17'h51]), 32'd0);
    bus.clr_err = 1'b1;
    tick();
    bus.clr_err = 1'b0;
    chk("ovr_clr", 32'(bus.overrun), 32'd0);

    // Out-of-frame address
    bus.wr_addr = 17'(FP);
    bus.wr_data = 8'h77;
    bus.wr_req  = 1'b1;
    tick();
    chk("oob_flag", 32'(bus.oob_err), 32'(BoundsEn));
    bus.wr_req = 1'b0;
    tick();
    chk("oob_we", 32'(bus.mem_we), 32'(!BoundsEn));
    tick();
    chk("oob_we_end", 32'(bus.mem_we), 32'd0);
    bus.clr_err = 1'b1;
    tick();
    bus.clr_err = 1'b0;
    chk("oob_clr", 32'(bus.oob_err), 32'd0);
    tick();

    // Reset during RD_WAIT, with wr_req held high across release
    bus.rd_addr = 17'h30;
    bus.rd_req  = 1'b1;
    tick();
    bus.rd_req = 1'b0;
    tick();
    tick();
    bus.wr_req = 1'b1;
    reset = 1'b0;
    #1;
    chk("mrst_busy",  32'(bus.rd_busy),   32'd0);
    chk("mrst_valid", 32'(bus.rd_valid),  32'd0);
    chk("mrst_addr",  32'(bus.mem_addr),  32'd0);
    chk("mrst_wdata", 32'(bus.mem_wdata), 32'd0);
    chk("mrst_rdata", 32'(bus.rd_data),   32'd0);
    @(negedge clk);
    reset = 1'b1;
    cnt = 0;
    repeat (6) begin
      tick();
      cnt += int'(bus.rd_valid) + int'(bus.mem_we);
    end
    chk("mrst_quiet", 32'(cnt), 32'd0);
    bus.wr_req = 1'b0;
    tick();
    bus.wr_addr = 17'h60;
    bus.wr_data = 8'h99;
    bus.wr_req  = 1'b1;
    tick();
    bus.wr_req = 1'b0;
    tick();
    chk("mrst_rearm_we",   32'(bus.mem_we),   32'd1);
    chk("mrst_rearm_addr", 32'(bus.mem_addr), 32'h60);
    tick();
    tick();

    // Random traffic: writes in order, reads return pattern data, bounded latency
    for (int i = 0; i < 700; i++) begin
      stim = (i < 670);
      if (bus.wr_req && ($urandom_range(2) == 0)) begin
        bus.wr_req = 1'b0;
      end else if (stim && !bus.wr_req && !wr_out && ($urandom_range(3) == 0)) begin
        bus.wr_addr = 17'h1000 + 17'($urandom_range(4095));
        bus.wr_data = 8'($urandom);
        bus.wr_req  = 1'b1;
        qa.push_back(bus.wr_addr);
        qd.push_back(bus.wr_data);
        wr_out = 1'b1;
        wr_age = 0;
      end
      if (!stim) bus.wr_req = 1'b0;
      if (stim && !rd_out && ($urandom_range(2) == 0)) begin
        bus.rd_addr = 17'h800 + 17'($urandom_range(255));
        bus.rd_req  = 1'b1;
        rd_exp = pat(bus.rd_addr);
        rd_out = 1'b1;
        rd_age = 0;
      end else if (stim && rd_out && ($urandom_range(3) == 0)) begin
        // Busy: must be ignored
        bus.rd_addr = 17'($urandom);
        bus.rd_req  = 1'b1;
      end
      tick();
      bus.rd_req = 1'b0;

      if (bus.mem_we) begin
        chk("rnd_we_expected", 32'(qa.size() != 0), 32'd1);
        if (qa.size() != 0) begin
          ea = qa.pop_front();
          ed = qd.pop_front();
          chk("rnd_we_addr",  32'(bus.mem_addr),  32'(ea));
          chk("rnd_we_wdata", 32'(bus.mem_wdata), 32'(ed));
        end
        wr_out = 1'b0;
      end
      if (bus.rd_valid) begin
        chk("rnd_rv_expected", 32'(rd_out), 32'd1);
        chk("rnd_rd_data", 32'(bus.rd_data), 32'(rd_exp));
        rd_out = 1'b0;
      end
      if (wr_out) begin
        wr_age++;
        chk("rnd_wr_timeout", 32'(wr_age > 8), 32'd0);
        if (wr_age > 8) begin
          wr_out = 1'b0;
          qa.delete();
          qd.delete();
        end
      end
      if (rd_out) begin
        rd_age++;
        chk("rnd_rd_timeout", 32'(rd_age > 8), 32'd0);
        if (rd_age > 8) rd_out = 1'b0;
      end
    end
    chk("rnd_wr_drained", 32'(qa.size()), 32'd0);
    chk("rnd_rd_drained", 32'(rd_out),    32'd0);
    chk("rnd_no_overrun", 32'(bus.overrun), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fb_port_arbiter.md
FB_PORT_ARBITER -- requirements
Module: fb_port_arbiter

Interface
REQ-001 SHALL have parameters: ADDR_W, default 17, address width; DATA_W, default 8, pixel width; FRAME_PIXELS, default 76800, pixel count of one frame.
REQ-002 SHALL have ports: reset input 1, asynchronous, active-low; clk input 1, clock.
REQ-003 SHALL have write-side ports: wr_req input 1, capture write-enable level; wr_addr input ADDR_W; wr_data input DATA_W.
REQ-004 SHALL have read-side ports: rd_req input 1, one-cycle read request pulse; rd_addr input ADDR_W; rd_busy output 1; rd_data output DATA_W; rd_valid output 1.
REQ-005 SHALL have memory-side ports: mem_addr output ADDR_W; mem_wdata output DATA_W; mem_we output 1; mem_rdata input DATA_W (synchronous RAM, 1-cycle read latency).
REQ-006 SHALL have status ports: clr_err input 1; overrun output 1, sticky; oob_err output 1, sticky.

Function
REQ-007 SHALL register wr_req each clk (wr_req_q); a write event SHALL be wr_req=1 and wr_req_q=0 at an edge, so one write is issued per level assertion however long it is held.
REQ-008 On a write event, SHALL latch wr_addr/wr_data and set wr_pend at that edge.
REQ-009 SHALL accept rd_req only when rd_busy=0; SHALL then latch rd_addr, set rd_pend and set rd_busy; rd_req while rd_busy=1 SHALL be ignored.
REQ-010 FSM states SHALL be IDLE, WRITE, READ, RD_WAIT; all outputs registered.
REQ-011 IDLE: if wr_pend and (not rd_pend or last grant was READ) -> WRITE; else if rd_pend -> READ; else stay.
REQ-012 WRITE: mem_we=1, mem_addr/mem_wdata = latched write values, for exactly one cycle; clear wr_pend; last grant=WRITE; -> IDLE.
REQ-013 READ: mem_addr = latched rd_addr, mem_we=0; last grant=READ; -> RD_WAIT.
REQ-014 RD_WAIT: at exit edge capture mem_rdata into rd_data, pulse rd_valid for one cycle, clear rd_pend and rd_busy; -> IDLE.
REQ-015 Uncontended write: event sampled at edge k -> mem_we high from edge k+1 to edge k+2.
REQ-016 Uncontended read: rd_req sampled at edge k -> mem_addr=rd_addr from edge k+1; rd_valid high from edge k+3 to k+4.
REQ-017 Both pending in IDLE SHALL alternate grants (no starvation); worst-case write wait 4 cycles.
REQ-018 Write event while wr_pend=1 and not clearing that edge: new write discarded, older kept, overrun set.
REQ-019 Write event on the same edge WRITE clears wr_pend: new write becomes pending, overrun unchanged.
REQ-020 clr_err=1 SHALL clear overrun and oob_err at the next edge; a simultaneous error event SHALL win (flag stays set).
REQ-021 rd_data SHALL hold its last value until the next rd_valid.

Reset
REQ-022 reset=0 SHALL immediately force: mem_we=0, mem_addr=0, mem_wdata=0, rd_data=0, rd_valid=0, rd_busy=0, overrun=0, oob_err=0, wr_pend=0, rd_pend=0, wr_req_q=0, last grant=READ, state IDLE.
REQ-023 Reset mid-operation SHALL abort any write or read; an aborted read SHALL produce no rd_valid.
REQ-024 After reset release with wr_req already high, no write event SHALL occur until wr_req falls and rises again.

Configuration
REQ-025 With FB_ARB_BOUNDS_CHECK_EN defined: a write event with wr_addr >= FRAME_PIXELS SHALL set oob_err and SHALL NOT set wr_pend (no mem_we).
REQ-026 Without FB_ARB_BOUNDS_CHECK_EN: all writes SHALL be issued regardless of address; oob_err SHALL be constant 0.

Verification
REQ-027 wr_req high 10 cycles, wr_addr=0x00005, wr_data=0xA5 -> exactly one mem_we cycle, mem_addr=0x00005, mem_wdata=0xA5.
REQ-028 rd_req pulse, rd_addr=0x00010, RAM holds 0x3C -> rd_valid one cycle 3 edges after request, rd_data=0x3C; second rd_req while rd_busy ignored.
REQ-029 Write event and rd_req on same edge, then repeated -> grants alternate WRITE, READ, WRITE; no request lost.
REQ-030 Second write event while first is pending behind a read -> first written, second dropped, overrun=1; clr_err -> overrun=0.
REQ-031 FB_ARB_BOUNDS_CHECK_EN defined, wr_addr=76800 -> no mem_we, oob_err=1; undefined -> mem_we issued, oob_err=0.
REQ-032 reset asserted in RD_WAIT -> all outputs 0 immediately, no rd_valid after release.
